// File: rtl/inst_fetch.sv
// inst_fetch: initiator side of the instruction-memory interface.
// Owns the PC, issues one word fetch per cycle while the queue has room,
// captures the combinationally returned word into an in-order queue and
// presents the queue head to decode over a valid/ready handshake.
// A redirect flushes the queue and reloads the PC.
//
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   fetch_en        - 0 pauses fetching and holds the PC
//   mem_ce          - memory chip-enable (fetch this cycle)
//   mem_pc          - byte address of the word being fetched (registered)
//   mem_inst        - instruction returned combinationally for mem_pc
//   redirect_valid  - taken branch/jump resolved this cycle
//   redirect_pc     - new fetch target (low two bits ignored)
//   out_valid       - queue head holds a valid instruction
//   out_inst        - head instruction (0 when out_valid=0)
//   out_pc          - byte address of head instruction (0 when out_valid=0)
//   out_ready       - decode accepts the head this cycle
module inst_fetch #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             INST_WIDTH = 32,
    parameter int unsigned             DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic                  mem_ce,
    output logic [ADDR_WIDTH-1:0] mem_pc,
    input  logic [INST_WIDTH-1:0] mem_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [INST_WIDTH-1:0] ent_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] ent_pc_q   [DEPTH];

    logic push;
    logic pop;

    // Full test looks at count only so out_ready never reaches mem_ce.
    assign mem_ce    = !rst && fetch_en && !redirect_valid && (count_q < CNT_W'(DEPTH));
    assign mem_pc    = pc_q;
    assign push      = mem_ce;
    assign out_valid = (count_q != '0);
    // A handshake coinciding with a redirect is void and not consumed.
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign out_inst  = out_valid ? ent_inst_q[head_q] : '0;
    assign out_pc    = out_valid ? ent_pc_q[head_q]   : '0;

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + ADDR_WIDTH'(4);
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: it is only read while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_inst_q[tail_q] <= mem_inst;
            ent_pc_q[tail_q]   <= pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Memory word at byte address a is
// 0x1000 + a/4. Inputs change shortly after the rising edge; outputs are
// checked 2 time units after the edge.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_ce;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .mem_ce         (mem_ce),
        .mem_pc         (mem_pc),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_inst = mem_ce ? (32'h1000 + (mem_pc >> 2)) : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        tick();
        n_tests++;
        if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce_during_rst: got %b want 0", mem_ce); end
        n_tests++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b inst=%h pc=%h want 0/0/0", out_valid, out_inst, out_pc);
        end
        n_tests++;
        if (mem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_mem_pc: got %h want 0", mem_pc); end
        rst = 1'b0;
        #1;
        n_tests++;
        if (mem_ce !== 1'b1 || mem_pc !== 32'h0) begin
            n_fail++; $display("FAIL first_fetch: ce=%b pc=%h want 1/0", mem_ce, mem_pc);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== 32'(32'h1000 + k)) begin
                n_fail++; $display("FAIL stream_%0d: valid=%b pc=%h inst=%h want 1/%h/%h",
                                   k, out_valid, out_pc, out_inst, 32'(4 * k), 32'(32'h1000 + k));
            end
        end
    endtask

    task automatic test_full();
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (mem_ce !== 1'b1 || mem_pc !== 32'(4 * k)) begin
                n_fail++; $display("FAIL fill_%0d: ce=%b pc=%h want 1/%h", k, mem_ce, mem_pc, 32'(4 * k));
            end
            tick();
        end
        n_tests++;
        if (mem_ce !== 1'b0 || mem_pc !== 32'h10 || out_pc !== 32'h0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL full_stall: ce=%b mem_pc=%h out_pc=%h valid=%b want 0/10/0/1",
                               mem_ce, mem_pc, out_pc, out_valid);
        end
        tick();
        n_tests++;
        if (mem_ce !== 1'b0 || mem_pc !== 32'h10) begin
            n_fail++; $display("FAIL full_hold: ce=%b pc=%h want 0/10", mem_ce, mem_pc);
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_fetch: ce=%b want 0", mem_ce); end
        tick();
        n_tests++;
        if (out_pc !== 32'h4 || mem_ce !== 1'b1 || mem_pc !== 32'h10) begin
            n_fail++; $display("FAIL drain_resume: out_pc=%h ce=%b mem_pc=%h want 4/1/10", out_pc, mem_ce, mem_pc);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h8 || out_inst !== 32'h1002) begin
            n_fail++; $display("FAIL drain_8: pc=%h inst=%h want 8/1002", out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'hC || out_inst !== 32'h1003) begin
            n_fail++; $display("FAIL drain_c: pc=%h inst=%h want c/1003", out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h10 || out_inst !== 32'h1004) begin
            n_fail++; $display("FAIL drain_10: pc=%h inst=%h want 10/1004", out_pc, out_inst);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        tick(); tick(); tick();
        n_tests++;
        if (out_pc !== 32'h8) begin n_fail++; $display("FAIL redir_pre: out_pc=%h want 8", out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        #1;
        n_tests++;
        if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL redir_ce: got %b want 0", mem_ce); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mem_pc !== 32'h40 || mem_ce !== 1'b1) begin
            n_fail++; $display("FAIL redir_flush: valid=%b mem_pc=%h ce=%b want 0/40/1", out_valid, mem_pc, mem_ce);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h1010) begin
            n_fail++; $display("FAIL redir_first: valid=%b pc=%h inst=%h want 1/40/1010", out_valid, out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h44) begin n_fail++; $display("FAIL redir_second: pc=%h want 44", out_pc); end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        tick(); tick(); tick(); tick();
        n_tests++;
        if (mem_ce !== 1'b0 || out_pc !== 32'h0) begin
            n_fail++; $display("FAIL rfull_pre: ce=%b out_pc=%h want 0/0", mem_ce, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mem_pc !== 32'h80) begin
            n_fail++; $display("FAIL rfull_flush: valid=%b mem_pc=%h want 0/80", out_valid, mem_pc);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_inst !== 32'h1020) begin
            n_fail++; $display("FAIL rfull_first: valid=%b pc=%h inst=%h want 1/80/1020", out_valid, out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h84) begin n_fail++; $display("FAIL rfull_second: pc=%h want 84", out_pc); end
    endtask

    task automatic test_pc_wrap();
        do_reset(1'b1);
        tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (mem_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_target: mem_pc=%h want fffffff8", mem_pc); end
        tick();
        n_tests++;
        if (out_pc !== 32'hFFFF_FFF8 || out_inst !== 32'h4000_0FFE) begin
            n_fail++; $display("FAIL wrap_0: pc=%h inst=%h want fffffff8/40000ffe", out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'hFFFF_FFFC || out_inst !== 32'h4000_0FFF || mem_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_1: pc=%h inst=%h mem_pc=%h want fffffffc/40000fff/0", out_pc, out_inst, mem_pc);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h0 || out_inst !== 32'h1000) begin
            n_fail++; $display("FAIL wrap_2: pc=%h inst=%h want 0/1000", out_pc, out_inst);
        end
        tick();
        n_tests++;
        if (out_pc !== 32'h4) begin n_fail++; $display("FAIL wrap_3: pc=%h want 4", out_pc); end
    endtask

    task automatic test_mid_reset();
        do_reset(1'b0);
        tick(); tick(); tick();
        n_tests++;
        if (out_valid !== 1'b1 || mem_pc !== 32'hC) begin
            n_fail++; $display("FAIL mrst_pre: valid=%b mem_pc=%h want 1/c", out_valid, mem_pc);
        end
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        n_tests++;
        if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL mrst_ce: got %b want 0", mem_ce); end
        tick();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mem_pc !== 32'h0 || mem_ce !== 1'b1) begin
            n_fail++; $display("FAIL mrst_post: valid=%b mem_pc=%h ce=%b want 0/0/1", out_valid, mem_pc, mem_ce);
        end
    endtask

    task automatic test_fetch_en();
        do_reset(1'b0);
        tick(); tick(); tick();
        fetch_en  = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (mem_ce !== 1'b0 || mem_pc !== 32'hC) begin
                n_fail++; $display("FAIL fen_hold_%0d: ce=%b pc=%h want 0/c", k, mem_ce, mem_pc);
            end
            n_tests++;
            if (k < 3) begin
                if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
                    n_fail++; $display("FAIL fen_drain_%0d: valid=%b pc=%h want 1/%h", k, out_valid, out_pc, 32'(4 * k));
                end
            end else begin
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL fen_empty_%0d: valid=%b want 0", k, out_valid);
                end
            end
            tick();
        end
        fetch_en = 1'b1;
        #1;
        n_tests++;
        if (mem_ce !== 1'b1 || mem_pc !== 32'hC) begin
            n_fail++; $display("FAIL fen_resume: ce=%b pc=%h want 1/c", mem_ce, mem_pc);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'hC || out_inst !== 32'h1003) begin
            n_fail++; $display("FAIL fen_first: valid=%b pc=%h inst=%h want 1/c/1003", out_valid, out_pc, out_inst);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_redirect_full();
        test_pc_wrap();
        test_mid_reset();
        test_fetch_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
